fifo_wr_arbiter: RTL and testbench

//  Shares the write port of one synchronous FIFO (FIFO_WIDTH x FIFO_DEPTH) among NUM_REQ producers.
//  - Round-robin arbitration with bounded bursts.
//  - Throttles on full/almostfull so the FIFO never sees a write it cannot take.
//  - Tracks write acknowledgements and latches overflow errors.
//  - Sits between the producer blocks and the FIFO's data_in/wr_en inputs.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Brief    : Shared types, defaults and helpers for the FIFO write arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int c_DEF_NUM_REQ    = 4;
    localparam int c_DEF_FIFO_WIDTH = 16;
    localparam int c_DEF_MAX_BURST  = 2;
    localparam int c_DEF_CNT_W      = 16;

    // Index width that stays legal (>=1) even for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Rotating-priority encoder; first set request after ptr, with wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan farthest-to-nearest so the nearest candidate after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            logic [IW-1:0] w_cand;
            w_cand = IW'((int'(ptr) + k) % N);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Round-robin, burst-bounded arbiter for a shared FIFO write port.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = c_DEF_NUM_REQ,
    parameter int FIFO_WIDTH = c_DEF_FIFO_WIDTH,
    parameter int MAX_BURST  = c_DEF_MAX_BURST,
    parameter int CNT_W      = c_DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [CNT_W-1:0]              wr_cnt,
    output logic                          err_overflow,
    output logic                          err_ack
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t          r_state, w_state_nxt;
    logic [IW-1:0]       r_owner, w_owner_nxt;
    logic [IW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [BW-1:0]       r_beat_cnt, w_beat_nxt;
    logic [CNT_W-1:0]    r_outstanding;

    logic                w_can_write;
    logic                w_found;
    logic [IW-1:0]       w_winner;
    logic                w_accept;
    logic [IW-1:0]       w_acc_idx;
    logic [FIFO_WIDTH-1:0] w_acc_data;

    // A registered write still in flight already consumes the last free slot.
    assign w_can_write = !fifo_full && !(fifo_almostfull && fifo_wr_en);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_winner)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= IW'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_beat_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (MAX_BURST == 1) begin
                        w_rr_ptr_nxt = w_winner;
                    end else begin
                        w_state_nxt = OWN;
                        w_owner_nxt = w_winner;
                        w_beat_nxt  = BW'(1);
                    end
                end
            end
            OWN: begin
                if (!req_valid[r_owner]) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = r_owner;
                end else if (w_accept) begin
                    if (r_beat_cnt == BW'(MAX_BURST - 1)) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = r_owner;
                    end else begin
                        w_beat_nxt = r_beat_cnt + BW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: handshake and accepted-beat selection
    always_comb begin
        req_ready = '0;
        w_accept  = 1'b0;
        w_acc_idx = r_owner;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_found && w_can_write) begin
                        req_ready[w_winner] = 1'b1;
                        w_accept            = 1'b1;
                        w_acc_idx           = w_winner;
                    end
                end
                OWN: begin
                    if (req_valid[r_owner] && w_can_write) begin
                        req_ready[r_owner] = 1'b1;
                        w_accept           = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_acc_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_acc_idx == IW'(i)) begin
                w_acc_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Write datapath: one-cycle registered path to the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            grant_id     <= '0;
            wr_cnt       <= '0;
        end else begin
            fifo_wr_en <= w_accept;
            if (w_accept) begin
                fifo_data_in <= w_acc_data;
                grant_id     <= w_acc_idx;
                wr_cnt       <= wr_cnt + c_CNT_ONE;
            end
        end
    end

    // Ack tracking and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            err_overflow  <= 1'b0;
            err_ack       <= 1'b0;
        end else begin
            case ({fifo_wr_en, fifo_wr_ack})
                2'b10: r_outstanding <= r_outstanding + c_CNT_ONE;
                2'b01: begin
                    if (r_outstanding == '0) begin
                        err_ack <= 1'b1;
                    end else begin
                        r_outstanding <= r_outstanding - c_CNT_ONE;
                    end
                end
                default: ;
            endcase
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Brief    : Scoreboard bench for fifo_wr_arbiter against a rule-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 2;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_almostfull = 1'b0;
    logic            fifo_wr_ack = 1'b0;
    logic            fifo_overflow = 1'b0;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_data_in;
    logic [1:0]      grant_id;
    logic [CW-1:0]   wr_cnt;
    logic            err_overflow;
    logic            err_ack;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .grant_id(grant_id), .wr_cnt(wr_cnt),
        .err_overflow(err_overflow), .err_ack(err_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [W-1:0] data;
        logic [1:0]  id;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [W-1:0] wr_log[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    // Reference model: owner < 0 means nobody holds the port.
    int m_owner, m_beats, m_ptr, m_cnt;
    bit m_wr_en;

    bit ack_en = 1'b0, ack_force = 1'b0, ovf_pulse = 1'b0, prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every expected write must appear exactly one cycle after its accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_en", 32'(fifo_wr_en), 32'd1);
                chk("data", 32'(fifo_data_in), 32'(e.data));
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("wr_cnt", 32'(wr_cnt), 32'(e.cnt));
            end else begin
                chk("spurious_wr_en", 32'(fifo_wr_en), 32'd0);
            end
            if (fifo_wr_en) wr_log.push_back(fifo_data_in);
        end
    end

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_ptr = N - 1; m_cnt = 0; m_wr_en = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: drive at negedge, check req_ready, advance the model.
    task automatic step(input logic [N-1:0] v, input logic f, input logic af, input bit rnd);
        bit can;
        int win, acc, c;
        logic [N-1:0] exp_ready;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        for (int i = 0; i < N; i++)
            req_data[i*W +: W] = rnd ? W'($urandom) : W'(16'h0A00 | i);
        fifo_full = f;
        fifo_almostfull = af;
        fifo_wr_ack = ack_force | (ack_en & prev_wr);
        prev_wr = fifo_wr_en;
        fifo_overflow = ovf_pulse;
        ack_force = 1'b0;
        ovf_pulse = 1'b0;
        #1;
        can = !f && !(af && m_wr_en);
        exp_ready = '0;
        acc = -1;
        win = -1;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (win < 0 && v[c]) win = c;
            end
            if (win >= 0 && can) acc = win;
        end else if (v[m_owner] && can) begin
            acc = m_owner;
        end
        if (acc >= 0) exp_ready[acc] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (acc >= 0) begin
            m_cnt++;
            e.due = cyc + 1;
            e.data = req_data[acc*W +: W];
            e.id = 2'(acc);
            e.cnt = CW'(m_cnt);
            sb.push_back(e);
        end
        if (m_owner < 0) begin
            if (acc >= 0) begin
                if (MB == 1) m_ptr = acc;
                else begin m_owner = acc; m_beats = 1; end
            end
        end else if (!v[m_owner]) begin
            m_ptr = m_owner; m_owner = -1;
        end else if (acc >= 0) begin
            m_beats++;
            if (m_beats == MB) begin m_ptr = m_owner; m_owner = -1; end
        end
        m_wr_en = (acc >= 0);
    endtask

    // Assert reset away from any edge and confirm outputs clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_data", 32'(fifo_data_in), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_errs", 32'({err_overflow, err_ack}), 32'd0);
        req_valid = '0; req_data = '0; fifo_full = 1'b0; fifo_almostfull = 1'b0;
        fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
        prev_wr = 1'b0; ack_force = 1'b0; ovf_pulse = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_order [9];
        exp_order = '{16'h0A00, 16'h0A00, 16'h0A01, 16'h0A01, 16'h0A02,
                      16'h0A02, 16'h0A03, 16'h0A03, 16'h0A00};
        model_reset();
        do_reset();

        // Mid-run reset, then requester 0 must win first.
        ack_en = 1'b1;
        for (int i = 0; i < 7; i++) step(4'($urandom), 1'b0, 1'b0, 1'b1);
        do_reset();
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("first_grant_after_rst", 32'(req_ready), 32'b0001);

        // Full rotation with bursts of two.
        do_reset();
        wr_log.delete();
        for (int i = 0; i < 9; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("order_len", 32'(wr_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < wr_log.size(); i++)
            chk($sformatf("order[%0d]", i), 32'(wr_log[i]), 32'(exp_order[i]));

        // Owner drops valid after one beat: bubble, then next requester.
        do_reset();
        step(4'b0110, 1'b0, 1'b0, 1'b0);
        chk("owner1_grant", 32'(req_ready), 32'b0010);
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        chk("drop_bubble", 32'(req_ready), 32'b0000);
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        chk("next_grant", 32'(req_ready), 32'b0100);

        // Almost-full with a write in flight stalls without losing ownership.
        do_reset();
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 1'b0);
        chk("almostfull_stall", 32'(req_ready), 32'b0000);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("full_stall", 32'(req_ready), 32'b0000);
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("owner_kept", 32'(req_ready), 32'b0001);
        step(4'b0000, 1'b0, 1'b0, 1'b0);

        // Sticky overflow error.
        ovf_pulse = 1'b1;
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("err_overflow_set", 32'(err_overflow), 32'd1);
        for (int i = 0; i < 100; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("err_overflow_held", 32'(err_overflow), 32'd1);
        do_reset();

        // Spurious ack, then clean acked traffic.
        ack_en = 1'b0;
        ack_force = 1'b1;
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("err_ack_set", 32'(err_ack), 32'd1);
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 16; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("wr_cnt_16", 32'(wr_cnt), 32'd16);
        chk("err_ack_clean", 32'(err_ack), 32'd0);

        // Randomised traffic and throttling.
        do_reset();
        for (int i = 0; i < 2000; i++)
            step(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rand_sb_drained", 32'(sb.size()), 32'd0);
        chk("rand_wr_cnt", 32'(wr_cnt), 32'(CW'(m_cnt)));
        chk("rand_err_ack", 32'(err_ack), 32'd0);
        chk("rand_err_overflow", 32'(err_overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
